// File: rtl/reset_pkg.sv
// Shared types and 48 MHz-derived defaults for the board reset sequencer and its helpers.
package reset_pkg;

  localparam int unsigned CLK_HZ              = 48_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 1_000;      // 1 ms
  localparam int unsigned HOLD_CYCLES_DEF     = CLK_HZ / 100_000;    // 10 us
  localparam int unsigned STAGE_GAP_DEF       = CLK_HZ / 1_000_000;  // 1 us
  localparam int unsigned ACK_TIMEOUT_DEF     = CLK_HZ / 10;         // 100 ms
  localparam int unsigned FAULT_STAGE_W       = 3;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_EXT = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  // Counter width for a terminal count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side bundle of the reset sequencer: reset sources, stage acks and sequenced outputs.
interface reset_sequencer_if #(
  parameter int unsigned N_STAGES = 4
);
  import reset_pkg::*;

  logic                     ext_reset;
  logic                     sw_reset_req;
  logic [N_STAGES-1:0]      stage_ready;
  logic [N_STAGES-1:0]      stage_reset_n;
  logic                     clk_en;
  logic                     seq_done;
  logic                     fault;
  logic [FAULT_STAGE_W-1:0] fault_stage;

  modport master (
    output ext_reset, sw_reset_req, stage_ready,
    input  stage_reset_n, clk_en, seq_done, fault, fault_stage
  );

  modport slave (
    input  ext_reset, sw_reset_req, stage_ready,
    output stage_reset_n, clk_en, seq_done, fault, fault_stage
  );

endinterface

// File: rtl/reset_debounce.sv
// Two-flop synchroniser plus stability counter; the level follows the input only after
// CYCLES consecutive identical synchronised samples. Shared with board pushbuttons.
module reset_debounce
  import reset_pkg::*;
#(
  parameter int unsigned CYCLES      = DEBOUNCE_CYCLES_DEF,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  localparam int unsigned      CNT_W    = cnt_width(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Counter only runs while the sample disagrees with the level, so it stops at CNT_LAST.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
    end else begin
      sync_q  <= {sync_q[0], async_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: holds all subsystem resets, then releases them in order,
// waiting for each ready ack, and enables the downstream clock once every stage is up.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned N_STAGES        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned STAGE_GAP       = STAGE_GAP_DEF,
  parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  reset_sequencer_if.slave  bus
);

  localparam int unsigned              CNT_W     = cnt_width(max3(HOLD_CYCLES, STAGE_GAP,
                                                                  ACK_TIMEOUT));
  localparam logic [CNT_W-1:0]         CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]         HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]         GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]         ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam int unsigned              IDX_W     = FAULT_STAGE_W;
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(N_STAGES - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [N_STAGES-1:0]      stage_rst_q, stage_rst_d;
  logic                     clk_en_q, seq_done_q, fault_q;
  logic [FAULT_STAGE_W-1:0] fault_stage_q, fault_stage_d;
  logic [N_STAGES-1:0]      release_mask;
  logic                     ack;
  logic                     ext_db;

  reset_debounce #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_LEVEL (1'b0)
  ) u_ext_db (
    .clk_i   (clk_48mhz),
    .rst_ni  (reset_n),
    .async_i (bus.ext_reset),
    .level_o (ext_db)
  );

  assign release_mask = N_STAGES'(1) << idx_q;
  assign ack          = |(bus.stage_ready & release_mask);
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next state, shared cycle counter and next register values for every output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    fault_stage_d = fault_stage_q;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q >= HOLD_LAST) begin
          state_d = ST_WAIT_EXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_EXT: begin
        if (ext_db) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        stage_rst_d   = stage_rst_q | release_mask;
        fault_stage_d = '0;
        state_d       = ST_WAIT_ACK;
        cnt_d         = '0;
      end
      ST_WAIT_ACK: begin
        // An ack in the final timer cycle still wins over the timeout.
        if (ack) begin
          state_d = (idx_q == LAST_IDX) ? ST_RUN : ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q >= ACK_LAST) begin
          state_d       = ST_FAULT;
          fault_stage_d = idx_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = ST_RELEASE;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN:   ;
      ST_FAULT: ;
      default:  state_d = ST_HOLD;
    endcase

    // WAIT_EXT is where a low external line is expected, so only a software request aborts it.
    if ((state_q != ST_HOLD) &&
        (bus.sw_reset_req || (!ext_db && (state_q != ST_WAIT_EXT)))) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end

    if ((state_d == ST_HOLD) || (state_d == ST_FAULT)) begin
      stage_rst_d = '0;
    end else if (state_d == ST_RUN) begin
      stage_rst_d = '1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_q   <= '0;
      clk_en_q      <= 1'b0;
      seq_done_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      clk_en_q      <= (state_d == ST_RUN);
      seq_done_q    <= (state_d == ST_RUN);
      fault_q       <= (state_d == ST_FAULT);
      fault_stage_q <= fault_stage_d;
    end
  end

  assign bus.stage_reset_n = stage_rst_q;
  assign bus.clk_en        = clk_en_q;
  assign bus.seq_done      = seq_done_q;
  assign bus.fault         = fault_q;
  assign bus.fault_stage   = fault_stage_q;

endmodule
